// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver. It feeds a small receive FIFO that the CPU reads over the registered-read data bus.
// It also raises a level interrupt flag with a matching clear strobe.
module uart_rx_mmio #(
   parameter logic [15:0] BASE_ADDR    = 16'h1010,
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  din,
   input  logic [15:0] address,
   input  logic        w_en,
   input  logic        r_en,
   output logic [7:0]  dout,
   input  logic        rx,
   output logic        rx_flag,
   input  logic        rx_flag_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [15:0]   HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0]   FULL_M1 = 16'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   // S_BREAK holds off after a framing error until the line returns high.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_s_q, rx_s_prev_q;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovr_q, ovr_d, ferr_q, ferr_d;
   logic          rx_en_q, rx_en_d, irq_en_q, irq_en_d;
   logic [7:0]    dout_q, dout_d;
   logic          rx_flag_q, rx_flag_d;

   logic          push_req, ferr_set, push_ok, ovr_set, pop;
   logic          fifo_ne, fifo_full, rd_hit, wr_hit;
   logic [15:0]   offset;
   logic [7:0]    status;
   logic          unused_din;

   assign unused_din = ^din[7:2];
   assign dout       = dout_q;
   assign rx_flag    = rx_flag_q;

   // Receive FSM: every decision uses the synchronised line rx_s_q.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push_req  = 1'b0;
      ferr_set  = 1'b0;
      if (!rx_en_q) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rx_s_prev_q && !rx_s_q) begin
                  state_d = S_START;
                  cnt_d   = HALF_M1;
               end
            end
            S_START: begin
               if (cnt_q == 16'd0) begin
                  if (!rx_s_q) begin
                     state_d   = S_DATA;
                     cnt_d     = FULL_M1;
                     bit_idx_d = 3'd0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            S_DATA: begin
               if (cnt_q == 16'd0) begin
                  shift_d[bit_idx_q] = rx_s_q;
                  cnt_d              = FULL_M1;
                  bit_idx_d          = bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_d = S_STOP;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            S_STOP: begin
               if (cnt_q == 16'd0) begin
                  if (rx_s_q) begin
                     push_req = 1'b1;
                     state_d  = S_IDLE;
                  end else begin
                     ferr_set = 1'b1;
                     state_d  = S_BREAK;
                  end
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            S_BREAK: begin
               if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Bus decode, FIFO bookkeeping, status and interrupt.
   always_comb begin
      offset    = address - BASE_ADDR;
      rd_hit    = r_en && (offset < 16'd4);
      wr_hit    = w_en && (offset < 16'd4);
      fifo_ne   = (count_q != '0);
      fifo_full = (count_q == DEPTH_C);
      pop       = rd_hit && (offset[1:0] == 2'd0) && fifo_ne;
      // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
      push_ok   = push_req && (!fifo_full || pop);
      ovr_set   = push_req && !push_ok;
      status    = {4'b0000, ferr_q, ovr_q, fifo_full, fifo_ne};

      dout_d = dout_q;
      if (rd_hit) begin
         case (offset[1:0])
            2'd0:    dout_d = fifo_ne ? mem_q[rptr_q] : 8'h00;
            2'd1:    dout_d = status;
            2'd2:    dout_d = {6'b000000, irq_en_q, rx_en_q};
            default: dout_d = 8'(count_q);
         endcase
      end

      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok) begin
         mem_d[wptr_q] = shift_q;
         wptr_d        = wptr_q + AW'(1);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (!push_ok && pop) count_d = count_q - CW'(1);

      ovr_d    = ovr_q;
      ferr_d   = ferr_q;
      rx_en_d  = rx_en_q;
      irq_en_d = irq_en_q;
      if (wr_hit && offset[1:0] == 2'd1) begin
         ovr_d  = 1'b0;
         ferr_d = 1'b0;
      end
      if (ovr_set)  ovr_d  = 1'b1;
      if (ferr_set) ferr_d = 1'b1;
      if (wr_hit && offset[1:0] == 2'd2) begin
         rx_en_d  = din[0];
         irq_en_d = din[1];
      end

      rx_flag_d = rx_flag_q;
      if (rx_flag_clr)          rx_flag_d = 1'b0;
      if (push_ok && irq_en_q)  rx_flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_s_prev_q <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= 16'd0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         ovr_q       <= 1'b0;
         ferr_q      <= 1'b0;
         rx_en_q     <= 1'b0;
         irq_en_q    <= 1'b0;
         dout_q      <= 8'h00;
         rx_flag_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         rx_s_prev_q <= rx_s_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         ovr_q       <= ovr_d;
         ferr_q      <= ferr_d;
         rx_en_q     <= rx_en_d;
         irq_en_q    <= irq_en_d;
         dout_q      <= dout_d;
         rx_flag_q   <= rx_flag_d;
      end
   end

   // Storage needs no reset: count_q alone decides which entries are valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio: directed scenarios plus randomized frames and bus traffic.
// Results are compared against a queue-based register model.
module tb_uart_rx_mmio;

   localparam int          C     = 16;
   localparam int          DEPTH = 4;
   localparam logic [15:0] BASE  = 16'h1010;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  din;
   logic [15:0] address;
   logic        w_en, r_en;
   logic [7:0]  dout;
   logic        rx;
   logic        rx_flag;
   logic        rx_flag_clr;

   uart_rx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .address(address), .w_en(w_en),
      .r_en(r_en), .dout(dout), .rx(rx), .rx_flag(rx_flag), .rx_flag_clr(rx_flag_clr)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] exp_q[$];
   logic       m_ovr, m_ferr, m_rx_en, m_irq_en, m_flag;
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ovr = 0; m_ferr = 0; m_rx_en = 0; m_irq_en = 0; m_flag = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; rx = 1; r_en = 0; w_en = 0; rx_flag_clr = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      @(negedge clk);
      address = a; r_en = 1;
      @(negedge clk);
      r_en = 0;
      d = dout;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a; din = d; w_en = 1;
      @(negedge clk);
      w_en = 0;
      if (a == BASE + 16'd1) begin m_ovr = 0; m_ferr = 0; end
      if (a == BASE + 16'd2) begin m_rx_en = d[0]; m_irq_en = d[1]; end
   endtask

   // Expected register value from the model; RXDATA pops the model queue.
   task automatic reg_check(input logic [1:0] off, input string tag);
      logic [7:0] got, exp;
      case (off)
         2'd0: exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
         2'd1: exp = {4'b0, m_ferr, m_ovr, exp_q.size() == DEPTH, exp_q.size() != 0};
         2'd2: exp = {6'b0, m_irq_en, m_rx_en};
         default: exp = 8'(exp_q.size());
      endcase
      bus_read(BASE + 16'(off), got);
      check(tag, got, exp);
   endtask

   task automatic drive_frame(input logic [7:0] data, input logic stop_bit, input int stop_len);
      @(negedge clk);
      rx = 0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (C) @(negedge clk);
      end
      rx = stop_bit;
      repeat (stop_len) @(negedge clk);
      rx = 1;
      repeat (C) @(negedge clk);
   endtask

   task automatic model_frame(input logic [7:0] data, input logic good);
      if (m_rx_en) begin
         if (!good) m_ferr = 1;
         else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(data);
            if (m_irq_en) m_flag = 1;
         end else m_ovr = 1;
      end
   endtask

   task automatic send_frame(input logic [7:0] data);
      drive_frame(data, 1'b1, C);
      model_frame(data, 1'b1);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      rx_flag_clr = 1;
      @(negedge clk);
      rx_flag_clr = 0;
      m_flag = 0;
   endtask

   logic [7:0] rd;
   logic       seen;

   initial begin
      rst_n = 0; rx = 1; din = 0; address = 0; w_en = 0; r_en = 0; rx_flag_clr = 0;
      do_reset();
      check("reset_dout", dout, 8'h00);
      check("reset_flag", rx_flag, 1'b0);
      reg_check(2'd1, "reset_status");
      reg_check(2'd3, "reset_count");
      reg_check(2'd2, "reset_ctrl");

      // Basic reception
      bus_write(BASE + 16'd2, 8'h03);
      reg_check(2'd2, "ctrl_03");
      send_frame(8'hA5);
      check("a5_flag", rx_flag, m_flag);
      reg_check(2'd1, "a5_status");
      reg_check(2'd3, "a5_count");
      reg_check(2'd0, "a5_data");
      repeat (3) @(negedge clk);
      check("dout_hold", dout, 8'hA5);
      bus_read(BASE + 16'd4, rd);
      check("oow_high", rd, 8'hA5);
      bus_read(16'h100F, rd);
      check("oow_low", rd, 8'hA5);
      reg_check(2'd1, "a5_status_after");
      reg_check(2'd0, "empty_read");
      pulse_clr();
      check("flag_cleared", rx_flag, 1'b0);

      // Simultaneous read and write of CTRL returns the old value
      @(negedge clk);
      address = BASE + 16'd2; din = 8'h02; r_en = 1; w_en = 1;
      @(negedge clk);
      r_en = 0; w_en = 0;
      check("rw_old", dout, 8'h03);
      m_rx_en = 0; m_irq_en = 1;
      reg_check(2'd2, "rw_new");
      bus_write(BASE + 16'd2, 8'h03);

      // Clear held through the set cycle: set wins
      rx_flag_clr = 1;
      seen = 0;
      fork
         drive_frame(8'h3C, 1'b1, C);
         begin
            for (int i = 0; i < 400 && !seen; i++) begin
               @(negedge clk);
               if (rx_flag) begin seen = 1; rx_flag_clr = 0; end
            end
            rx_flag_clr = 0;
         end
      join
      model_frame(8'h3C, 1'b1);
      check("set_wins_seen", seen, 1'b1);
      check("set_wins_flag", rx_flag, m_flag);
      pulse_clr();
      check("clr_flag", rx_flag, 1'b0);
      reg_check(2'd0, "3c_data");

      // Overrun
      for (int i = 1; i <= 5; i++) send_frame(8'(i));
      reg_check(2'd1, "ovr_status");
      reg_check(2'd3, "ovr_count");
      for (int i = 0; i < 4; i++) reg_check(2'd0, "ovr_data");
      reg_check(2'd0, "ovr_empty");
      bus_write(BASE + 16'd1, 8'hFF);
      reg_check(2'd1, "ovr_cleared");
      pulse_clr();

      // Framing error with line held low
      drive_frame(8'h00, 1'b0, 40);
      model_frame(8'h00, 1'b0);
      reg_check(2'd1, "ferr_status");
      reg_check(2'd3, "ferr_count");
      send_frame(8'h5A);
      reg_check(2'd0, "after_ferr_data");
      bus_write(BASE + 16'd1, 8'h00);
      reg_check(2'd1, "ferr_cleared");
      pulse_clr();

      // Glitch, then disabled receiver
      @(negedge clk);
      rx = 0;
      repeat (4) @(negedge clk);
      rx = 1;
      repeat (3 * C) @(negedge clk);
      reg_check(2'd1, "glitch_status");
      reg_check(2'd3, "glitch_count");
      bus_write(BASE + 16'd2, 8'h00);
      send_frame(8'hFF);
      reg_check(2'd3, "disabled_count");
      bus_write(BASE + 16'd2, 8'h03);
      send_frame(8'h96);
      reg_check(2'd0, "after_glitch_data");

      // Reset in the middle of DATA bit 3
      send_frame(8'h77);
      reg_check(2'd2, "pre_reset_ctrl");
      @(negedge clk);
      rx = 0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = i[0];
         repeat (C) @(negedge clk);
      end
      rx = 1;
      repeat (C / 2) @(negedge clk);
      do_reset();
      check("midreset_dout", dout, 8'h00);
      check("midreset_flag", rx_flag, 1'b0);
      reg_check(2'd1, "midreset_status");
      reg_check(2'd3, "midreset_count");
      reg_check(2'd2, "midreset_ctrl");
      reg_check(2'd0, "midreset_data");
      bus_write(BASE + 16'd2, 8'h03);
      send_frame(8'h81);
      reg_check(2'd0, "post_reset_81");
      pulse_clr();

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 6))
            0, 1, 2: send_frame(8'($urandom_range(0, 255)));
            3: begin
               if ($urandom_range(0, 3) == 0) begin
                  drive_frame(8'($urandom_range(0, 255)), 1'b0, C);
                  model_frame(8'h00, 1'b0);
               end else reg_check(2'($urandom_range(0, 3)), "rand_read");
            end
            4: reg_check(2'($urandom_range(0, 3)), "rand_read");
            5: begin
               if ($urandom_range(0, 1) == 0) bus_write(BASE + 16'd1, 8'($urandom_range(0, 255)));
               else bus_write(BASE + 16'd2, {6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                                               1'($urandom_range(0, 3) != 0)});
            end
            default: pulse_clr();
         endcase
         check("rand_flag", rx_flag, m_flag);
      end
      reg_check(2'd1, "final_status");
      reg_check(2'd3, "final_count");
      for (int i = 0; i < DEPTH + 1; i++) reg_check(2'd0, "final_drain");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
